mux_arb_nx1: RTL
================

# mux_arb_nx1

Parametrised N-to-1 multiplexer with built-in arbitration, valid/ready handshake on every channel and a one-entry registered output stage. It supersedes the fixed 2-to-1 32-bit selector wherever several datapath producers compete for a single consumer, such as a write-back port, a memory request port or a bus. Selection is driven by channel requests rather than an external `sel`. The index of the winning channel travels with the data.

## Interface
Parameters:
- `WIDTH`, 32: data width per channel, ≥1.
- `N`, 4: number of input channels, ≥1; any value, not only powers of two.
- `SELW`, derived as `$clog2(N)`, forced to 1 when N=1: width of the channel index.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `e` input N*WIDTH: flattened channel data; channel i occupies `e[i*WIDTH +: WIDTH]`.
- `e_valid` input N: per-channel request; bit i means channel i presents a word.
- `e_ready` output N: per-channel accept; at most one bit is high per cycle.
- `sal` output WIDTH: registered output word.
- `sal_sel` output SELW: index of the channel that produced `sal`.
- `sal_valid` output 1: `sal`/`sal_sel` hold an unconsumed word.
- `sal_ready` input 1: consumer accepts the word.

## Operation
- Transfer on channel i: `e_valid[i] && e_ready[i]` at a rising edge.
- Output transfer: `sal_valid && sal_ready` at a rising edge.
- Arbitration is combinational each cycle over `e_valid`. The result is a one-hot `grant` (all-zero if no request).
- `room = !sal_valid || sal_ready`, so the output register is free or is emptying this cycle.
- `e_ready[i] = grant[i] && room`.
  - `e_ready` depends combinationally on `e_valid` and `sal_ready`.
  - `e_ready[i]` is never high while `e_valid[i]` is low.
- On an input transfer from channel k:
  - `sal <= e[k]`, `sal_sel <= k`, `sal_valid <= 1`.
  - Arbitration pointer `ptr <= (k == N-1) ? 0 : k+1`.
- On an output transfer with no input transfer: `sal_valid <= 0`. `sal` and `sal_sel` keep their last values.
- When neither transfer happens, all registers hold.
- Simultaneous input and output transfer: the new word replaces the old one and `sal_valid` stays 1. This gives full throughput of one word per cycle.
- Producers keep `e_valid[i]` and their data stable until accepted. The block does not check this.
- A requesting channel that is not granted is not accepted and loses nothing. It is re-arbitrated next cycle.
- Arbitration scheme is selected by the Configuration macro below.

## Timing
- Latency: a word accepted at edge t appears on `sal` with `sal_valid=1` after edge t, so it is visible in cycle t+1.
- Throughput: 1 word/cycle while `sal_ready=1` and at least one `e_valid` bit is set.
- Reset values after any edge with `reset=1`:
  - `sal_valid=0`, `sal={WIDTH{0}}`, `sal_sel=0`, `ptr=0`.
  - `e_ready=0` for the whole cycle in which `reset` is high. Arbitration is gated by `!reset`.
- Reset mid-operation: any held word is discarded and no handshake completes in the reset cycle.
- Backpressure: with `sal_valid=1` and `sal_ready=0`, all of `e_ready` is 0 and `sal`/`sal_sel` are stable.
- N=1:
  - `ptr` stays 0 and `sal_sel` is always 0.
  - The block acts as a one-entry pipeline register with handshake.
- Non-power-of-two N: `ptr` wraps from N-1 to 0. Indices ≥N are never produced.

## Configuration
- Macro `MUX_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - The granted channel is the first requesting channel at or after `ptr`, scanning upward with wrap.
  - Any continuously requesting channel is granted within N accepted transfers.
- Undefined: fixed-priority arbitration.
  - The lowest-index requesting channel wins.
  - `ptr` is not implemented; its update is removed.
  - Higher-index channels may starve.
- Interface and handshake timing are identical in both builds.

## Test plan
- Reset: hold `reset=1` with `e_valid=4'b1111` and `sal_ready=1` for 2 cycles.
  - Required: `e_ready=0`, `sal_valid=0`, `sal=0`, `sal_sel=0` throughout.
- Single channel (N=4, WIDTH=32): drive `e_valid=4'b0100` with data 0xCAFE0002 for one cycle, `sal_ready=1`.
  - Required: `e_ready=4'b0100`.
  - Next cycle: `sal=0xCAFE0002`, `sal_sel=2`, `sal_valid=1`.
  - Following cycle: `sal_valid=0`.
- Round-robin, macro defined: hold `e_valid=4'b1111` and `sal_ready=1` for 8 cycles.
  - Required: `sal_sel` sequence 0,1,2,3,0,1,2,3, one word per cycle.
  - Without the macro: `sal_sel` is 0 every cycle.
- Backpressure: fill the output with 0x11 from channel 1, then `sal_ready=0` for 3 cycles while `e_valid=4'b1001`.
  - Required: `e_ready=0`, `sal=0x11` and `sal_sel=1` stable.
  - On `sal_ready=1`: 0x11 is consumed and channel 3 is accepted in the same edge (RR build; ptr=2).
- Non-power-of-two wrap (N=3): hold `e_valid=3'b111` and `sal_ready=1`.
  - Required: `sal_sel` sequence 0,1,2,0, never 3.
- Reset mid-stream: assert `reset` while `sal_valid=1` and `sal_ready=0`.
  - Required: next cycle `sal_valid=0` and `sal_sel=0`.
  - After release with `e_valid=4'b1111`: channel 0 is granted first.

Source files
------------

// File: rtl/mux_arb_nx1.sv
// N-to-1 arbitrating multiplexer with valid/ready channels and a one-entry output register.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mux_arb_nx1 #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] e,
    input  logic [N-1:0]       e_valid,
    output logic [N-1:0]       e_ready,
    output logic [WIDTH-1:0]   sal,
    output logic [SELW-1:0]    sal_sel,
    output logic               sal_valid,
    input  logic               sal_ready
);

    logic [N-1:0]     grant;
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             found;
    logic             room;
    logic             take;

    // Stage p0: combinational arbitration over the current requests
`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0] ptr;
    logic            found_hi;

    // First pass picks the lowest requester (the wrap-around candidate); the second
    // pass overrides it with the lowest requester at or above ptr when one exists.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        found    = 1'b0;
        found_hi = 1'b0;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (e_valid[i] && !found) begin
                    found    = 1'b1;
                    win_idx  = SELW'(i);
                    win_data = e[i*WIDTH +: WIDTH];
                end
            end
            for (int i = 0; i < N; i++) begin
                if (e_valid[i] && (i >= int'(ptr)) && !found_hi) begin
                    found_hi = 1'b1;
                    win_idx  = SELW'(i);
                    win_data = e[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (win_idx == SELW'(N - 1)) ? '0 : win_idx + SELW'(1);
        end
    end
`else
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        found    = 1'b0;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (e_valid[i] && !found) begin
                    found    = 1'b1;
                    win_idx  = SELW'(i);
                    win_data = e[i*WIDTH +: WIDTH];
                end
            end
        end
    end
`endif

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = found && (win_idx == SELW'(i));
        end
    end

    assign room    = !sal_valid || sal_ready;
    assign e_ready = grant & {N{room}};
    assign take    = |e_ready;

    // Stage p1: output register; a simultaneous accept and drain keeps sal_valid high
    always_ff @(posedge clk) begin
        if (reset) begin
            sal_valid <= 1'b0;
            sal       <= '0;
            sal_sel   <= '0;
        end else if (take) begin
            sal_valid <= 1'b1;
            sal       <= win_data;
            sal_sel   <= win_idx;
        end else if (sal_valid && sal_ready) begin
            sal_valid <= 1'b0;
        end
    end

endmodule
